// File: rtl/uart_rx_stop_checker.sv
// UART receiver stop-bit checker: samples STOP_BITS stop bits, flags framing errors and breaks.
// Define STOP_MAJORITY_EN to replace the single mid-bit sample with a 2-of-3 majority vote.
module uart_rx_stop_checker #(
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned PRESCALE  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic data_in,
    input  logic start,
    input  logic data_zero,
    output logic busy,
    output logic done,
    output logic stop_error,
    output logic break_det
);

    localparam int unsigned TW = $clog2(PRESCALE);
    localparam logic [TW-1:0] TickLast = TW'(PRESCALE - 1);
    localparam logic [TW-1:0] TickMid  = TW'(PRESCALE / 2 - 1);
    localparam logic [1:0]    BitLast  = 2'(STOP_BITS - 1);

    typedef enum logic [1:0] {StIdle, StSample, StReport} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [1:0]      bit_cnt_q, bit_cnt_d;
    logic            err_q, err_d;
    logic            all_zero_q, all_zero_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            stop_error_q, stop_error_d;
    logic            break_det_q, break_det_d;
    logic            samp_vld;
    logic            samp_val;

`ifdef STOP_MAJORITY_EN
    localparam logic [TW-1:0] TickPre  = TW'(PRESCALE / 2 - 2);
    localparam logic [TW-1:0] TickPost = TW'(PRESCALE / 2);
    logic maj_a_q, maj_a_d;
    logic maj_b_q, maj_b_d;
`endif

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        err_d        = err_q;
        all_zero_d   = all_zero_q;
        stop_error_d = stop_error_q;
        break_det_d  = break_det_q;
        samp_vld     = 1'b0;
        samp_val     = 1'b1;

`ifdef STOP_MAJORITY_EN
        maj_a_d = maj_a_q;
        maj_b_d = maj_b_q;
        if (state_q == StSample && sample_tick) begin
            if (tick_cnt_q == TickPre) maj_a_d = data_in;
            if (tick_cnt_q == TickMid) maj_b_d = data_in;
            if (tick_cnt_q == TickPost) begin
                samp_vld = 1'b1;
                samp_val = (maj_a_q & maj_b_q) | (maj_a_q & data_in) | (maj_b_q & data_in);
            end
        end
`else
        if (state_q == StSample && sample_tick && tick_cnt_q == TickMid) begin
            samp_vld = 1'b1;
            samp_val = data_in;
        end
`endif

        case (state_q)
            StSample: begin
                if (sample_tick) begin
                    if (samp_vld) begin
                        if (!samp_val) err_d = 1'b1;
                        else           all_zero_d = 1'b0;
                    end
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BitLast) begin
                            state_d      = StReport;
                            stop_error_d = err_d;
                            break_det_d  = all_zero_d & data_zero;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 2'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
            end
            default: begin
                // IDLE and REPORT both accept a new frame
                if (start) begin
                    state_d      = StSample;
                    tick_cnt_d   = '0;
                    bit_cnt_d    = '0;
                    err_d        = 1'b0;
                    all_zero_d   = 1'b1;
                    stop_error_d = 1'b0;
                    break_det_d  = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase

        busy_d = (state_d == StSample);
        done_d = (state_d == StReport);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            err_q        <= 1'b0;
            all_zero_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stop_error_q <= 1'b0;
            break_det_q  <= 1'b0;
`ifdef STOP_MAJORITY_EN
            maj_a_q      <= 1'b1;
            maj_b_q      <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            err_q        <= err_d;
            all_zero_q   <= all_zero_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            stop_error_q <= stop_error_d;
            break_det_q  <= break_det_d;
`ifdef STOP_MAJORITY_EN
            maj_a_q      <= maj_a_d;
            maj_b_q      <= maj_b_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign stop_error = stop_error_q;
    assign break_det  = break_det_q;

endmodule

// File: tb/tb_uart_rx_stop_checker.sv
// Bench for uart_rx_stop_checker (PRESCALE=8, STOP_BITS=2): frame-level model plus literal checks.
module tb_uart_rx_stop_checker;

    localparam int P  = 8;
    localparam int SB = 2;
    localparam int NT = P * SB;

    logic clk = 1'b0;
    logic reset, sample_tick, data_in, start, data_zero;
    logic busy, done, stop_error, break_det;

    uart_rx_stop_checker #(.STOP_BITS(SB), .PRESCALE(P)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .data_in    (data_in),
        .start      (start),
        .data_zero  (data_zero),
        .busy       (busy),
        .done       (done),
        .stop_error (stop_error),
        .break_det  (break_det)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    // Frame-level model: record the line level at every tick, judge the frame once all ticks are in
    bit   m_busy, m_done, m_se, m_bd;
    int   m_ticks;
    logic wave [NT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_se = 0; m_bd = 0; m_ticks = 0;
    endtask

    task automatic model_judge(input logic dz);
        bit any0 = 0;
        bit all0 = 1;
        for (int b = 0; b < SB; b++) begin
            int  base = b * P;
            bit  s;
`ifdef STOP_MAJORITY_EN
            s = (int'(wave[base+P/2-2]) + int'(wave[base+P/2-1]) + int'(wave[base+P/2])) >= 2;
`else
            s = wave[base+P/2-1];
`endif
            if (!s) any0 = 1;
            else    all0 = 0;
        end
        m_se = any0;
        m_bd = all0 && dz;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else if (m_busy) begin
            if (sample_tick) begin
                wave[m_ticks] = data_in;
                m_ticks++;
                if (m_ticks == NT) begin
                    model_judge(data_zero);
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else begin
            m_done = 0;
            if (start) begin
                m_busy = 1; m_ticks = 0; m_se = 0; m_bd = 0;
            end
        end
    endtask

    task automatic step(input logic st, input logic tk, input logic din, input logic dz);
        start = st; sample_tick = tk; data_in = din; data_zero = dz;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    always @(negedge clk)
        if (chk_en)
            chk("cycle", {28'd0, busy, done, stop_error, break_det}, {28'd0, m_busy, m_done, m_se, m_bd});

    always @(posedge clk) if (done === 1'b1) n_done++;

    // Start, then nt ticks of pat; gap cycles before each tick carry a stray start and the wrong level
    task automatic frame(input logic [15:0] pat, input logic dz, input int gap, input int nt);
        step(1'b1, 1'b0, 1'b1, dz);
        chk("start_busy", busy, 1);
        chk("start_clear", {stop_error, break_det}, 0);
        for (int i = 0; i < nt; i++) begin
            for (int g = 0; g < gap; g++) step(g == 0, 1'b0, ~pat[i], dz);
            step(1'b0, 1'b1, pat[i], dz);
        end
    endtask

    initial begin
        int dn;
        reset = 1'b1; start = 0; sample_tick = 0; data_in = 1; data_zero = 0;
        model_reset();
        #2;
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) step(i[0], 1'b1, 1'b0, 1'b1);
        chk("reset_hold", {busy, done, stop_error, break_det}, 0);
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // good frame, tick every cycle
        frame(16'hFFFF, 1'b0, 0, NT);
        chk("good_done", done, 1);
        chk("good_res", {stop_error, break_det}, 2'b00);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("good_done_off", done, 0);
        chk("good_hold", {busy, stop_error, break_det}, 3'b000);

        // good frame with gaps and stray starts
        frame(16'hFFFF, 1'b0, 2, NT);
        chk("gap_done", done, 1);
        chk("gap_res", {stop_error, break_det}, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // bad second stop bit
        frame(16'h00FF, 1'b0, 1, NT);
        chk("bad2_res", {stop_error, break_det}, 2'b10);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bad2_hold", {stop_error, break_det}, 2'b10);

        // break, then restart in the done cycle
        frame(16'h0000, 1'b1, 0, NT);
        chk("brk_done", done, 1);
        chk("brk_res", {stop_error, break_det}, 2'b11);
        frame(16'hFFFF, 1'b0, 0, NT);
        chk("after_brk", {stop_error, break_det}, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // single-tick glitch at tick 4
        frame(16'hFFF7, 1'b0, 1, NT);
`ifdef STOP_MAJORITY_EN
        chk("glitch_se", stop_error, 0);
`else
        chk("glitch_se", stop_error, 1);
`endif
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // abort mid-frame
        dn = n_done;
        frame(16'hFFFF, 1'b0, 0, 5);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("abort_async", {busy, done, stop_error, break_det}, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("abort_no_done", n_done, dn);
        frame(16'hFFFF, 1'b0, 1, NT);
        chk("post_abort", {done, stop_error, break_det}, 3'b100);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("done_total", n_done, 7);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_stop_checker.md
UART_RX_STOP_CHECKER -- requirements
Module: uart_rx_stop_checker

Interface
REQ-001 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits checked per frame; legal values are 1 and 2.
REQ-002 The block SHALL have parameter PRESCALE, default 8, giving sample_tick pulses per bit period; legal values are even and >=4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port sample_tick, input, 1 bit: a one-clk oversampling strobe, PRESCALE per bit.
REQ-006 The block SHALL have port data_in, input, 1 bit: the synchronised serial line.
REQ-007 The block SHALL have port start, input, 1 bit: a one-clk pulse marking the leading edge of the first stop bit.
REQ-008 The block SHALL have port data_zero, input, 1 bit: high when all data bits of the current frame were 0; sampled on the done cycle.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in SAMPLE.
REQ-010 The block SHALL have port done, output, 1 bit: a one-clk pulse that occurs when the check completes.
REQ-011 The block SHALL have port stop_error, output, 1 bit: high when any stop-bit sample was 0.
REQ-012 The block SHALL have port break_det, output, 1 bit: high on a break condition.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SAMPLE, REPORT.
REQ-014 In IDLE, when start=1, the FSM SHALL move to SAMPLE, clear tick_cnt, bit_cnt and the error accumulator, and clear stop_error and break_det.
REQ-015 In SAMPLE, each sample_tick SHALL increment tick_cnt (width clog2(PRESCALE)); when tick_cnt=PRESCALE-1, tick_cnt SHALL wrap to 0 and bit_cnt SHALL increment.
REQ-016 The bit value SHALL be taken at tick_cnt=PRESCALE/2-1; if the bit value is 0, the error accumulator SHALL be set.
REQ-017 On the tick that wraps tick_cnt while bit_cnt=STOP_BITS-1, the FSM SHALL move to REPORT.
REQ-018 In that same cycle, stop_error SHALL be registered from the accumulator, and break_det SHALL be registered as (all stop-bit samples 0) AND data_zero.
REQ-019 REPORT SHALL last exactly one clk, with done=1; done latency SHALL be 1 clk after the final sample_tick.
REQ-020 The FSM SHALL then return to IDLE.
REQ-021 stop_error and break_det SHALL hold their values until the next accepted start or reset.
REQ-022 start while in SAMPLE SHALL be ignored; no restart.
REQ-023 start during the REPORT cycle SHALL be accepted: done still pulses, and the next state is SAMPLE with results cleared.
REQ-024 A sample_tick absent for any number of cycles SHALL freeze the counters; there is no timeout.
REQ-025 sample_tick in IDLE or REPORT SHALL have no effect.
REQ-026 busy SHALL be 1 exactly in SAMPLE; done SHALL be 1 exactly in REPORT.

Reset
REQ-027 When reset=0, the block SHALL immediately force IDLE, clear all counters and the accumulator, and drive busy=0, done=0, stop_error=0, break_det=0, regardless of clk.
REQ-028 Reset asserted mid-SAMPLE SHALL abandon the frame with no done pulse.
REQ-029 The first start after reset release SHALL behave exactly as in REQ-014.

Configuration
REQ-030 When STOP_MAJORITY_EN is defined, each bit value SHALL be the 2-of-3 majority of data_in sampled at tick_cnt = PRESCALE/2-2, PRESCALE/2-1 and PRESCALE/2, with the decision made at PRESCALE/2.
REQ-031 When STOP_MAJORITY_EN is undefined, each bit value SHALL be the single sample at PRESCALE/2-1 and the majority logic SHALL be absent.
REQ-032 Interface and latency SHALL be identical whether or not STOP_MAJORITY_EN is defined.

Verification (PRESCALE=8, STOP_BITS=2 unless noted)
REQ-033 Reset: hold reset=0 with start toggling -> busy, done, stop_error, break_det all 0; IDLE.
REQ-034 Good frame: start, data_in=1 for 16 ticks -> busy for 16 ticks, done 1 clk after tick 16, stop_error=0, break_det=0, held afterwards.
REQ-035 Bad second stop: data_in=1 for ticks 1-8 and 0 for ticks 9-16, data_zero=0 -> stop_error=1, break_det=0.
REQ-036 Break: data_in=0 for all 16 ticks, data_zero=1 -> stop_error=1, break_det=1; then start in the done cycle -> both cleared next clk, busy=1.
REQ-037 Glitch: single-tick low at tick 4 only -> with STOP_MAJORITY_EN, stop_error=0; without, stop_error=1.
REQ-038 Abort: reset=0 at tick 5 of SAMPLE -> immediate IDLE, no done; after release, a good frame gives done and stop_error=0.
